// File: rtl/sm1511_motor_pwm.sv
// sm1511_motor_pwm: H-bridge PWM driver with duty ramping, a decel/dead-time
// sequence on direction reversal, and brake/enable overrides.
// Handshake: none; all inputs are level-sampled every clk_50 edge, and speed
// is sampled only at the PWM period boundary.
module sm1511_motor_pwm #(
  parameter int PWM_DIV      = 195,
  parameter int RAMP_STEP    = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       en,
  input  logic       brake,
  input  logic       dir,
  input  logic [7:0] speed,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic [7:0] duty,
  output logic       period_start,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DECEL = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  localparam int PW = (PWM_DIV < 2) ? 1 : $clog2(PWM_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV);
  // A zero dead-time request still spends one period in DEAD.
  localparam int DEAD_N = (DEAD_PERIODS < 1) ? 1 : DEAD_PERIODS;
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_N - 1);
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    dead_cnt;
  logic          ldir;
  logic          tick;
  logic          boundary;
  logic          pwm_on;

  assign tick     = (presc == PRESC_LAST);
  assign boundary = tick && (cnt == 8'hFF);
  assign pwm_on   = (cnt < duty);

  // Move cur toward tgt by at most RAMP_STEP using a 9-bit intermediate
  // that saturates at 0 and 255 and never passes the target.
  function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] dn;
    logic [7:0] res;
    up  = {1'b0, cur} + STEP9;
    dn  = {1'b0, cur} - STEP9;
    res = cur;
    if (up > 9'd255) up = 9'd255;
    if (dn[8]) dn = 9'd0;
    if (tgt > cur) begin
      res = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else if (tgt < cur) begin
      res = (dn < {1'b0, tgt}) ? tgt : dn[7:0];
    end
    return res;
  endfunction

  // Free-running prescaler, PWM counter and period-start pulse.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      presc        <= '0;
      cnt          <= 8'd0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 8'd1;
      period_start <= boundary;
    end
  end

  // Control FSM, duty ramp and registered bridge outputs.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      duty     <= 8'd0;
      dead_cnt <= 8'd0;
      ldir     <= 1'b1;
      pwm_a    <= 1'b0;
      pwm_b    <= 1'b0;
    end else if (brake) begin
      state    <= S_IDLE;
      duty     <= 8'd0;
      dead_cnt <= 8'd0;
      pwm_a    <= 1'b1;
      pwm_b    <= 1'b1;
    end else if (!en) begin
      state    <= S_IDLE;
      duty     <= 8'd0;
      dead_cnt <= 8'd0;
      pwm_a    <= 1'b0;
      pwm_b    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pwm_a <= 1'b0;
          pwm_b <= 1'b0;
          ldir  <= dir;
          state <= S_RUN;
        end
        S_RUN: begin
          pwm_a <= ldir & pwm_on;
          pwm_b <= ~ldir & pwm_on;
          if (boundary) duty <= ramp_to(duty, speed);
          if (dir != ldir) state <= S_DECEL;
        end
        S_DECEL: begin
          pwm_a <= ldir & pwm_on;
          pwm_b <= ~ldir & pwm_on;
          if (boundary) begin
            duty <= ramp_to(duty, 8'd0);
            if (ramp_to(duty, 8'd0) == 8'd0) begin
              state    <= S_DEAD;
              dead_cnt <= 8'd0;
            end
          end
        end
        default: begin
          // DEAD: bridge fully off; leave on the last dead boundary and
          // begin the new-direction ramp at that same boundary.
          pwm_a <= 1'b0;
          pwm_b <= 1'b0;
          if (boundary) begin
            if (dead_cnt == DEAD_LAST) begin
              dead_cnt <= 8'd0;
              ldir     <= dir;
              state    <= S_RUN;
              duty     <= ramp_to(duty, speed);
            end else begin
              dead_cnt <= dead_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sm1511_motor_pwm.md
SM1511_MOTOR_PWM -- requirements
Module: sm1511_motor_pwm

Interface
REQ-001 Parameters SHALL be:
- PWM_DIV, default 195, prescale terminal count; tick every PWM_DIV+1 clocks (about 1 kHz PWM at 50 MHz).
- RAMP_STEP, default 4, maximum duty change per PWM period.
- DEAD_PERIODS, default 2, idle PWM periods inserted on a direction reversal.

REQ-002 Ports SHALL be:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  drive enable.
- brake  in  1  brake request, highest priority.
- dir  in  1  requested direction, 1 = forward.
- speed  in  8  target duty, 0..255, from the speed-select filter.
- pwm_a  out  1  H-bridge input A.
- pwm_b  out  1  H-bridge input B.
- duty  out  8  currently applied duty.
- period_start  out  1  one-cycle pulse at each PWM period start.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 DECEL, 3 DEAD.

Function
REQ-003 Prescaler SHALL count 0..PWM_DIV, wrap to 0, and assert an internal tick in the cycle it equals PWM_DIV.
REQ-004 The 8-bit PWM counter SHALL increment only on tick and wrap 255->0; period_start SHALL be 1 for exactly the cycle after the counter wraps to 0.
REQ-005 Raw pwm SHALL be (counter < duty) when registered: duty 0 gives constant low, duty 255 gives 255/256 high.
REQ-006 duty SHALL change only on a period boundary (the cycle period_start asserts), except when forced to 0 by brake, en or reset.
REQ-007 At each boundary in RUN, duty SHALL move toward target by min(RAMP_STEP, |target-duty|) with no overshoot; the unsigned 9-bit intermediate SHALL saturate at 0 and 255.
REQ-008 The ramp target SHALL be speed in RUN and 0 in DECEL; speed SHALL be sampled at the boundary only.
REQ-009 A latched direction register (ldir) SHALL set the outputs:
- ldir = 1: pwm_a = pwm, pwm_b = 0.
- ldir = 0: pwm_a = 0, pwm_b = pwm.
REQ-010 Outputs SHALL be registered; latency from counter to pwm_a/pwm_b is 1 clock.
REQ-011 FSM transitions SHALL be:
- IDLE->RUN when en=1 and brake=0; ldir <= dir on entry.
- RUN->DECEL when dir != ldir.
- DECEL->DEAD at the boundary where duty reaches 0.
- DEAD->RUN after DEAD_PERIODS boundaries, latching ldir <= dir.
REQ-012 In DEAD, pwm_a = pwm_b = 0.
REQ-013 If dir returns to ldir during DECEL, the FSM SHALL still complete DECEL and DEAD; no abort.
REQ-014 brake=1 in any state SHALL, on the next clock, drive pwm_a = pwm_b = 1, force duty to 0, set state IDLE, and hold all of these while brake=1. brake SHALL override en.
REQ-015 en=0 with brake=0 SHALL, on the next clock, drive pwm_a = pwm_b = 0, force duty to 0, and set state IDLE.
REQ-016 Prescaler and PWM counter SHALL keep running in all states, so period timing is unaffected by brake or en.
REQ-017 In IDLE without brake, pwm_a = pwm_b = 0.

Reset
REQ-018 With rst_n = 0 at a clk_50 edge, the following SHALL be 0 on the following cycle: prescaler, counter, duty, DEAD count, pwm_a, pwm_b, period_start; state SHALL be IDLE and ldir SHALL be 1.
REQ-019 Reset mid-ramp or mid-DEAD SHALL abandon the operation with no residual state.
REQ-020 After release, the first period_start SHALL occur 256*(PWM_DIV+1) clocks later.

Verification (PWM_DIV=0, RAMP_STEP=4, DEAD_PERIODS=2)
REQ-021 en=1, dir=1, speed=12 -> duty 4, 8, 12 at the first three boundaries, then constant; pwm_a high 12 of 256 cycles; pwm_b=0.
REQ-022 Steady duty=12, then dir=0 -> duty 8, 4, 0 (DECEL); then two periods with both outputs low (DEAD); then RUN with ldir=0, pwm_b ramping 4, 8, 12.
REQ-023 duty=200, brake=1 mid-period -> next clock pwm_a = pwm_b = 1, duty=0, state IDLE; brake=0 with en=1 -> RUN, ramp restarts from 0.
REQ-024 speed=254, RAMP_STEP=4 -> duty reaches 252 then 254, never 256 or a wrapped value; speed=255 -> pwm high 255 cycles, low 1 per period.
REQ-025 rst_n=0 during DEAD -> next cycle all outputs 0, state IDLE; after release, period_start first asserts 256 clocks later.
REQ-026 speed toggled between 0 and 200 off the period boundary -> duty changes only on period_start cycles.
